// File: rtl/controle_vendas_if.sv
// Front-panel and display signals of the vending controller.
// The master drives the debounced buttons; the slave (controller) drives the display and pulses.
interface controle_vendas_if;
  logic       moeda1;
  logic       moeda2;
  logic       comprar;
  logic       cancelar;
  logic [3:0] codigo;
  logic       libera;
  logic       troco;
  logic       rejeita;
  logic       ocupado;

  modport master (
    output moeda1, moeda2, comprar, cancelar,
    input  codigo, libera, troco, rejeita, ocupado
  );

  modport slave (
    input  moeda1, moeda2, comprar, cancelar,
    output codigo, libera, troco, rejeita, ocupado
  );
endinterface

// File: rtl/controle_vendas.sv
// Vending-machine control FSM: coin credit, purchase, cancel/refund, and display code for the
// seven-segment decoder. Every output is registered.
module controle_vendas #(
  parameter int unsigned PRECO = 3,
  parameter int unsigned T_MSG = 4
) (
  input  logic                clk,
  input  logic                rst,
  controle_vendas_if.slave    bus
);

  localparam int unsigned TimerW = (T_MSG > 1) ? $clog2(T_MSG) : 1;
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(T_MSG - 1);
  localparam logic [2:0] Preco = 3'(PRECO);

  localparam logic [3:0] CodP   = 4'b1000;
  localparam logic [3:0] CodDot = 4'b1001;
  localparam logic [3:0] CodE   = 4'b0110;
  localparam logic [3:0] CodN   = 4'b0111;

  typedef enum logic [2:0] {StOcioso, StVenda, StTroco, StErro, StRecusa} state_e;

  state_e              state_q, state_d;
  logic [2:0]          credit_q, credit_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [3:0]          prev_q, prev_d;
  logic [3:0]          codigo_q, codigo_d;
  logic                libera_q, libera_d;
  logic                troco_q, troco_d;
  logic                rejeita_q, rejeita_d;
  logic                ocupado_q, ocupado_d;

  logic [3:0] in_w;
  logic [3:0] ev;
  logic       ev_m1, ev_m2, ev_cp, ev_cn;
  logic       ev_coin;

  assign in_w    = {bus.cancelar, bus.comprar, bus.moeda2, bus.moeda1};
  assign ev      = in_w & ~prev_q;
  assign ev_m1   = ev[0];
  assign ev_m2   = ev[1];
  assign ev_cp   = ev[2];
  assign ev_cn   = ev[3];
  assign ev_coin = ev_m1 | ev_m2;
  assign prev_d  = in_w;

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    timer_d   = timer_q;
    libera_d  = 1'b0;
    troco_d   = 1'b0;
    rejeita_d = 1'b0;

    unique case (state_q)
      StOcioso: begin
        if (ev_cn) begin
          rejeita_d = ev_coin;
          if (credit_q != 3'd0) begin
            state_d = StTroco;
            troco_d = 1'b1;
          end
        end else if (ev_cp) begin
          rejeita_d = ev_coin;
          timer_d   = TimerLoad;
          if (credit_q >= Preco) begin
            credit_d = credit_q - Preco;
            libera_d = 1'b1;
            state_d  = StVenda;
          end else begin
            state_d = StErro;
          end
        end else if (ev_m2) begin
          // A simultaneous 1-unit coin loses to the 2-unit coin.
          rejeita_d = ev_m1;
          if (credit_q <= 3'd3) begin
            credit_d = credit_q + 3'd2;
          end else begin
            rejeita_d = 1'b1;
            timer_d   = TimerLoad;
            state_d   = StRecusa;
          end
        end else if (ev_m1) begin
          if (credit_q <= 3'd4) begin
            credit_d = credit_q + 3'd1;
          end else begin
            rejeita_d = 1'b1;
            timer_d   = TimerLoad;
            state_d   = StRecusa;
          end
        end
      end
      StVenda: begin
        rejeita_d = ev_coin;
        if (timer_q == '0) begin
          if (credit_q != 3'd0) begin
            state_d = StTroco;
            troco_d = 1'b1;
          end else begin
            state_d = StOcioso;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StTroco: begin
        // Credit counts the units still owed for the current and following TROCO cycles.
        rejeita_d = ev_coin;
        credit_d  = (credit_q != 3'd0) ? credit_q - 3'd1 : 3'd0;
        if (credit_q <= 3'd1) begin
          state_d = StOcioso;
        end else begin
          troco_d = 1'b1;
        end
      end
      StErro, StRecusa: begin
        rejeita_d = ev_coin;
        if (timer_q == '0) begin
          state_d = StOcioso;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d  = StOcioso;
        credit_d = 3'd0;
        timer_d  = '0;
      end
    endcase
  end

  always_comb begin
    codigo_d = {1'b0, credit_d};
    unique case (state_d)
      StVenda:  codigo_d = CodP;
      StTroco:  codigo_d = CodDot;
      StErro:   codigo_d = CodE;
      StRecusa: codigo_d = CodN;
      default:  codigo_d = {1'b0, credit_d};
    endcase
    ocupado_d = (state_d != StOcioso);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StOcioso;
      credit_q  <= 3'd0;
      timer_q   <= '0;
      prev_q    <= 4'b1111;
      codigo_q  <= 4'b0000;
      libera_q  <= 1'b0;
      troco_q   <= 1'b0;
      rejeita_q <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      timer_q   <= timer_d;
      prev_q    <= prev_d;
      codigo_q  <= codigo_d;
      libera_q  <= libera_d;
      troco_q   <= troco_d;
      rejeita_q <= rejeita_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign bus.codigo  = codigo_q;
  assign bus.libera  = libera_q;
  assign bus.troco   = troco_q;
  assign bus.rejeita = rejeita_q;
  assign bus.ocupado = ocupado_q;

endmodule

// File: tb/tb_controle_vendas.sv
// Table-driven bench for controle_vendas with a queue scoreboard, plus hand-written sequences
// for input held through reset and reset aborting a refund.
module tb_controle_vendas;

  logic clk = 1'b0;
  logic rst = 1'b1;

  controle_vendas_if bus ();

  controle_vendas #(
    .PRECO(3),
    .T_MSG(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // in = {cancelar, comprar, moeda2, moeda1}; flags = {libera, troco, rejeita, ocupado}
  typedef struct packed {
    logic [3:0] in;
    logic [3:0] cod;
    logic [3:0] flags;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic [3:0] in, input logic [3:0] cod, input logic [3:0] flags);
    vec_t v;
    v.in = in;
    v.cod = cod;
    v.flags = flags;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.libera, bus.troco, bus.rejeita, bus.ocupado};
  endfunction

  // Drive inputs just after an edge, push the expectation, compare just after the next edge.
  task automatic step(input vec_t v);
    vec_t e;
    {bus.cancelar, bus.comprar, bus.moeda2, bus.moeda1} = v.in;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("codigo", bus.codigo, e.cod);
    chk("flags", flags_now(), e.flags);
  endtask

  task automatic step_in(input logic [3:0] in, input logic [3:0] cod, input logic [3:0] flags);
    vec_t v;
    v.in = in;
    v.cod = cod;
    v.flags = flags;
    step(v);
  endtask

  initial begin
    bus.moeda1 = 1'b0;
    bus.moeda2 = 1'b0;
    bus.comprar = 1'b0;
    bus.cancelar = 1'b0;

    // Accumulate and buy exact
    add(4'b0001, 4'd1, 4'b0000);
    add(4'b0000, 4'd1, 4'b0000);
    add(4'b0010, 4'd3, 4'b0000);
    add(4'b0000, 4'd3, 4'b0000);
    add(4'b0100, 4'd8, 4'b1001);
    add(4'b0000, 4'd8, 4'b0001);
    add(4'b0000, 4'd8, 4'b0001);
    add(4'b0000, 4'd8, 4'b0001);
    add(4'b0000, 4'd0, 4'b0000);
    // Buy with change: 2+2+1
    add(4'b0010, 4'd2, 4'b0000);
    add(4'b0000, 4'd2, 4'b0000);
    add(4'b0010, 4'd4, 4'b0000);
    add(4'b0000, 4'd4, 4'b0000);
    add(4'b0001, 4'd5, 4'b0000);
    add(4'b0000, 4'd5, 4'b0000);
    add(4'b0100, 4'd8, 4'b1001);
    add(4'b0000, 4'd8, 4'b0001);
    add(4'b0000, 4'd8, 4'b0001);
    add(4'b0000, 4'd8, 4'b0001);
    add(4'b0000, 4'd9, 4'b0101);
    add(4'b0000, 4'd9, 4'b0101);
    add(4'b0000, 4'd0, 4'b0000);
    // Insufficient credit
    add(4'b0010, 4'd2, 4'b0000);
    add(4'b0000, 4'd2, 4'b0000);
    add(4'b0100, 4'd6, 4'b0001);
    add(4'b0000, 4'd6, 4'b0001);
    add(4'b0000, 4'd6, 4'b0001);
    add(4'b0000, 4'd6, 4'b0001);
    add(4'b0000, 4'd2, 4'b0000);
    // Overflow, plus a coin refused while in the message state
    add(4'b0010, 4'd4, 4'b0000);
    add(4'b0000, 4'd4, 4'b0000);
    add(4'b0010, 4'd7, 4'b0011);
    add(4'b0000, 4'd7, 4'b0001);
    add(4'b0001, 4'd7, 4'b0011);
    add(4'b0000, 4'd7, 4'b0001);
    add(4'b0000, 4'd4, 4'b0000);
    // Cancel at credit 4: four refund pulses
    add(4'b1000, 4'd9, 4'b0101);
    add(4'b0000, 4'd9, 4'b0101);
    add(4'b0000, 4'd9, 4'b0101);
    add(4'b0000, 4'd9, 4'b0101);
    add(4'b0000, 4'd0, 4'b0000);
    // Buy and coin together at credit 3: purchase wins, coin refused
    add(4'b0001, 4'd1, 4'b0000);
    add(4'b0000, 4'd1, 4'b0000);
    add(4'b0010, 4'd3, 4'b0000);
    add(4'b0000, 4'd3, 4'b0000);
    add(4'b0101, 4'd8, 4'b1011);
    add(4'b0000, 4'd8, 4'b0001);
    add(4'b0000, 4'd8, 4'b0001);
    add(4'b0000, 4'd8, 4'b0001);
    add(4'b0000, 4'd0, 4'b0000);
    // Cancel at zero credit does nothing; two coins together: 2 taken, 1 refused
    add(4'b1000, 4'd0, 4'b0000);
    add(4'b0000, 4'd0, 4'b0000);
    add(4'b0011, 4'd2, 4'b0010);
    add(4'b0000, 4'd2, 4'b0000);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_codigo", bus.codigo, 4'd0);
    chk("reset_flags", flags_now(), 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) step(tbl[i]);

    // moeda1 held high through reset release: no credit change
    bus.moeda1 = 1'b1;
    rst = 1'b1;
    #1;
    chk("held_rst_codigo", bus.codigo, 4'd0);
    chk("held_rst_flags", flags_now(), 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step_in(4'b0001, 4'd0, 4'b0000);
    step_in(4'b0001, 4'd0, 4'b0000);
    step_in(4'b0000, 4'd0, 4'b0000);
    step_in(4'b0001, 4'd1, 4'b0000);

    // Credit 3, cancel, reset after first refund pulse
    step_in(4'b0010, 4'd3, 4'b0000);
    step_in(4'b0000, 4'd3, 4'b0000);
    step_in(4'b1000, 4'd9, 4'b0101);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_codigo", bus.codigo, 4'd0);
    chk("abort_flags", flags_now(), 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step_in(4'b0000, 4'd0, 4'b0000);
    step_in(4'b0000, 4'd0, 4'b0000);
    step_in(4'b0000, 4'd0, 4'b0000);
    step_in(4'b0001, 4'd1, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
